// File: rtl/enc_pkg.sv
// Shared definitions for the instruction encoder: op classes, error codes,
// FSM states, instruction field positions and word-packing helpers.
package enc_pkg;

  // Instruction class as presented on req_class
  typedef enum logic [1:0] {
    CLS_DP    = 2'b00,
    CLS_MEM   = 2'b01,
    CLS_BR    = 2'b10,
    CLS_UNSUP = 2'b11
  } op_class_t;

  // Error codes reported on err_code
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DP_IMM  = 3'd1;
  localparam logic [2:0] ERR_MEM_OFS = 3'd2;
  localparam logic [2:0] ERR_BR_OFS  = 3'd3;
  localparam logic [2:0] ERR_UNSUP   = 3'd4;

  // Encoder FSM states; ST_ROT is only reachable with the rotation search
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROT   = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Field bit positions, identical to the ones the decoder slices on
  localparam int COND_LSB = 28;
  localparam int OP_LSB   = 26;
  localparam int I_BIT    = 25;
  localparam int CMD_LSB  = 21;
  localparam int S_BIT    = 20;
  localparam int P_BIT    = 24;
  localparam int U_BIT    = 23;
  localparam int B_BIT    = 22;
  localparam int W_BIT    = 21;
  localparam int L_BIT    = 20;
  localparam int LINK_BIT = 24;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;

  // Data-processing word; op2 is either {8'b0, Rm} or {rot, imm8}
  function automatic logic [31:0] pack_dp(input logic [3:0] cond, input logic imm,
                                          input logic [3:0] cmd, input logic s,
                                          input logic [3:0] rn, input logic [3:0] rd,
                                          input logic [11:0] op2);
    logic [31:0] w;
    w = '0;
    w[COND_LSB +: 4] = cond;
    w[OP_LSB +: 2]   = 2'b00;
    w[I_BIT]         = imm;
    w[CMD_LSB +: 4]  = cmd;
    w[S_BIT]         = s;
    w[RN_LSB +: 4]   = rn;
    w[RD_LSB +: 4]   = rd;
    w[11:0]          = op2;
    return w;
  endfunction

  // Load/store word: immediate offset, pre-indexed, word access, no writeback
  function automatic logic [31:0] pack_mem(input logic [3:0] cond, input logic u,
                                           input logic l, input logic [3:0] rn,
                                           input logic [3:0] rd, input logic [11:0] imm12);
    logic [31:0] w;
    w = '0;
    w[COND_LSB +: 4] = cond;
    w[OP_LSB +: 2]   = 2'b01;
    w[I_BIT]         = 1'b0;
    w[P_BIT]         = 1'b1;
    w[U_BIT]         = u;
    w[B_BIT]         = 1'b0;
    w[W_BIT]         = 1'b0;
    w[L_BIT]         = l;
    w[RN_LSB +: 4]   = rn;
    w[RD_LSB +: 4]   = rd;
    w[11:0]          = imm12;
    return w;
  endfunction

  // Branch word: word offset in the low 24 bits
  function automatic logic [31:0] pack_br(input logic [3:0] cond, input logic link,
                                          input logic [23:0] off24);
    logic [31:0] w;
    w = '0;
    w[COND_LSB +: 4] = cond;
    w[OP_LSB +: 2]   = 2'b10;
    w[I_BIT]         = 1'b1;
    w[LINK_BIT]      = link;
    w[23:0]          = off24;
    return w;
  endfunction

endpackage

// File: rtl/enc_rot_check.sv
// Combinational test of one rotation candidate: imm32 is encodable at rot
// when imm32 == ROR(imm8, 2*rot), i.e. ROL(imm32, 2*rot) fits in 8 bits.
module enc_rot_check (
  input  logic [31:0] imm32,
  input  logic [3:0]  rot,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [5:0]  amt;
  logic [31:0] rotl;

  // Rotate left by twice the candidate; a shift of 32 yields zero so rot 0 is exact
  always_comb begin
    amt   = {1'b0, rot, 1'b0};
    rotl  = (imm32 << amt) | (imm32 >> (6'd32 - amt));
    match = (rotl[31:8] == 24'd0);
    imm8  = rotl[7:0];
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: packs field-level requests into 32-bit
// instruction words and writes them to the instruction-memory load port at
// an auto-incrementing address. Optional macro ENC_ROT_SEARCH_EN enables the
// 16-step rotated-immediate search; without it only rot 0 immediates encode.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_class,
  input  logic [3:0]        req_cond,
  input  logic [3:0]        req_cmd,
  input  logic              req_s,
  input  logic              req_imm,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rm,
  input  logic [31:0]       req_imm32,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state_reg;
  logic        ready_reg;

  // Rotation checker interface
  logic [31:0] rc_imm32;
  logic [3:0]  rc_rot;
  logic        rc_match;
  logic [7:0]  rc_imm8;

  // Decision made on the accepting edge
  logic        acc_rot;
  logic        acc_err;
  logic [2:0]  acc_code;
  logic [31:0] acc_word;
  logic [31:0] mem_abs;
  logic        br_ok;

`ifdef ENC_ROT_SEARCH_EN
  logic [3:0]  rot_reg;
  logic [3:0]  cond_reg;
  logic [3:0]  cmd_reg;
  logic        s_reg;
  logic [3:0]  rn_reg;
  logic [3:0]  rd_reg;
  logic [31:0] imm32_reg;

  assign rc_imm32 = imm32_reg;
  assign rc_rot   = rot_reg;
`else
  // Only rot 0 is tried, directly on the incoming immediate
  assign rc_imm32 = req_imm32;
  assign rc_rot   = 4'd0;
`endif

  enc_rot_check u_rot_check (
    .imm32 (rc_imm32),
    .rot   (rc_rot),
    .match (rc_match),
    .imm8  (rc_imm8)
  );

  // start wins over a simultaneous request
  assign req_ready = ready_reg && !start;

  // Validate and pre-pack the request being presented
  always_comb begin
    acc_rot  = 1'b0;
    acc_err  = 1'b0;
    acc_code = ERR_NONE;
    acc_word = '0;
    mem_abs  = req_imm32[31] ? (32'd0 - req_imm32) : req_imm32;
    br_ok    = (req_imm32[1:0] == 2'b00) &&
               ((req_imm32[31:25] == 7'h00) || (req_imm32[31:25] == 7'h7F));
    case (op_class_t'(req_class))
      CLS_DP: begin
        if (req_imm) begin
`ifdef ENC_ROT_SEARCH_EN
          acc_rot = 1'b1;
`else
          if (rc_match) begin
            acc_word = pack_dp(req_cond, 1'b1, req_cmd, req_s, req_rn, req_rd, {4'd0, rc_imm8});
          end else begin
            acc_err  = 1'b1;
            acc_code = ERR_DP_IMM;
          end
`endif
        end else begin
          acc_word = pack_dp(req_cond, 1'b0, req_cmd, req_s, req_rn, req_rd, {8'd0, req_rm});
        end
      end
      CLS_MEM: begin
        if (mem_abs[31:12] != 20'd0) begin
          acc_err  = 1'b1;
          acc_code = ERR_MEM_OFS;
        end else begin
          acc_word = pack_mem(req_cond, !req_imm32[31], req_s, req_rn, req_rd, mem_abs[11:0]);
        end
      end
      CLS_BR: begin
        if (!br_ok) begin
          acc_err  = 1'b1;
          acc_code = ERR_BR_OFS;
        end else begin
          acc_word = pack_br(req_cond, req_s, req_imm32[25:2]);
        end
      end
      CLS_UNSUP: begin
        acc_err  = 1'b1;
        acc_code = ERR_UNSUP;
      end
      default: begin
        acc_err  = 1'b1;
        acc_code = ERR_UNSUP;
      end
    endcase
  end

  // Encoder FSM with registered strobes, write data, address and error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ready_reg  <= 1'b1;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= BASE;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
`ifdef ENC_ROT_SEARCH_EN
      rot_reg    <= '0;
      cond_reg   <= '0;
      cmd_reg    <= '0;
      s_reg      <= 1'b0;
      rn_reg     <= '0;
      rd_reg     <= '0;
      imm32_reg  <= '0;
`endif
    end else begin
      imem_we   <= 1'b0;
      err_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            imem_addr <= BASE;
          end else if (req_valid) begin
            ready_reg <= 1'b0;
`ifdef ENC_ROT_SEARCH_EN
            rot_reg   <= '0;
            cond_reg  <= req_cond;
            cmd_reg   <= req_cmd;
            s_reg     <= req_s;
            rn_reg    <= req_rn;
            rd_reg    <= req_rd;
            imm32_reg <= req_imm32;
`endif
            if (acc_rot) begin
              state_reg <= ST_ROT;
            end else if (acc_err) begin
              state_reg <= ST_ERR;
              err_valid <= 1'b1;
              err_code  <= acc_code;
            end else begin
              state_reg  <= ST_WRITE;
              imem_we    <= 1'b1;
              imem_wdata <= acc_word;
              err_code   <= ERR_NONE;
            end
          end
        end
`ifdef ENC_ROT_SEARCH_EN
        ST_ROT: begin
          if (rc_match) begin
            state_reg  <= ST_WRITE;
            imem_we    <= 1'b1;
            imem_wdata <= pack_dp(cond_reg, 1'b1, cmd_reg, s_reg, rn_reg, rd_reg, {rot_reg, rc_imm8});
            err_code   <= ERR_NONE;
          end else if (rot_reg == 4'd15) begin
            state_reg <= ST_ERR;
            err_valid <= 1'b1;
            err_code  <= ERR_DP_IMM;
          end else begin
            rot_reg <= rot_reg + 4'd1;
          end
        end
`endif
        ST_WRITE: begin
          imem_addr <= imem_addr + 1'b1;
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
        ST_ERR: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan vectors plus
// randomized requests compared against an arithmetic reference model.
// Honours ENC_ROT_SEARCH_EN the same way as the design.
module tb_instr_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_class;
  logic [3:0]    req_cond, req_cmd;
  logic          req_s, req_imm;
  logic [3:0]    req_rn, req_rd, req_rm;
  logic [31:0]   req_imm32;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          err_valid;
  logic [2:0]    err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr = 0;
  int exp_code = 0;
  int txn      = 0;
  logic [31:0] last_word;
  logic [31:0] last_addr;
  logic [31:0] last_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_class  (req_class),
    .req_cond   (req_cond),
    .req_cmd    (req_cmd),
    .req_s      (req_s),
    .req_imm    (req_imm),
    .req_rn     (req_rn),
    .req_rd     (req_rd),
    .req_rm     (req_rm),
    .req_imm32  (req_imm32),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: expected outcome, word/code and latency from acceptance
  function automatic void model(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                                input logic s, input logic imm, input logic [3:0] rn, input logic [3:0] rd,
                                input logic [3:0] rm, input logic [31:0] v,
                                output bit is_err, output logic [31:0] word, output int code, output int lat);
    longint unsigned acc;
    longint unsigned dbl;
    longint unsigned x;
    longint          off;
    longint          mag;
    bit              found;
    int              rr;
    longint unsigned xx;
    is_err = 0; word = '0; code = 0; lat = 1;
    acc = longint'(cond) * 64'h1000_0000;
    off = $signed(v);
    if (cls == 2'd0) begin
      acc = acc + longint'(cmd) * 64'h20_0000 + longint'(s) * 64'h10_0000
                + longint'(rn) * 64'h1_0000 + longint'(rd) * 64'h1000;
      if (!imm) begin
        word = 32'(acc + longint'(rm));
      end else begin
        acc = acc + 64'h200_0000;
`ifdef ENC_ROT_SEARCH_EN
        found = 0; rr = 0; xx = 0;
        dbl = longint'(v) * 64'h1_0000_0000 + longint'(v);
        for (int r = 0; r < 16; r++) begin
          x = (dbl >> (32 - 2 * r)) % 64'h1_0000_0000;
          if (!found && x < 256) begin
            found = 1; rr = r; xx = x;
          end
        end
        if (found) begin
          word = 32'(acc + longint'(rr) * 256 + xx);
          lat  = 2 + rr;
        end else begin
          is_err = 1; code = 1; lat = 17;
        end
`else
        dbl = 0; x = 0; found = 0; rr = 0; xx = 0;
        if (v < 256) word = 32'(acc + longint'(v));
        else begin is_err = 1; code = 1; end
`endif
      end
    end else if (cls == 2'd1) begin
      mag = (off < 0) ? -off : off;
      if (mag > 4095) begin
        is_err = 1; code = 2;
      end else begin
        acc = acc + 64'h400_0000 + 64'h100_0000 + ((off >= 0) ? 64'h80_0000 : 64'h0)
                  + longint'(s) * 64'h10_0000 + longint'(rn) * 64'h1_0000 + longint'(rd) * 64'h1000
                  + longint'(mag);
        word = 32'(acc);
      end
    end else if (cls == 2'd2) begin
      if ((off % 4) != 0 || off < -(64'sd1 <<< 25) || off > (64'sd1 <<< 25) - 4) begin
        is_err = 1; code = 3;
      end else begin
        acc = acc + 2 * 64'h400_0000 + 64'h200_0000 + longint'(s) * 64'h100_0000
                  + longint'((off / 4 + 64'sd16777216) % 64'sd16777216);
        word = 32'(acc);
      end
    end else begin
      is_err = 1; code = 4;
    end
  endfunction

  // One request: present, accept, wait for the write or error, check against the model
  task automatic do_req(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic s, input logic imm, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [3:0] rm, input logic [31:0] v);
    bit          e_err;
    logic [31:0] e_word;
    int          e_code, e_lat, lat, w;
    model(cls, cond, cmd, s, imm, rn, rd, rm, v, e_err, e_word, e_code, e_lat);
    txn++;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    check_eq($sformatf("t%0d_ready_wait", txn), 32'(req_ready), 32'd1);
    req_class = cls; req_cond = cond; req_cmd = cmd; req_s = s; req_imm = imm;
    req_rn = rn; req_rd = rd; req_rm = rm; req_imm32 = v; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq($sformatf("t%0d_busy", txn), 32'(req_ready), 32'd0);
    lat = 1;
    while (!(imem_we || err_valid) && lat < 40) begin @(posedge clk); #1; lat++; end
    check_eq($sformatf("t%0d_latency", txn), 32'(lat), 32'(e_lat));
    if (e_err) begin
      check_eq($sformatf("t%0d_err_valid", txn), 32'(err_valid), 32'd1);
      check_eq($sformatf("t%0d_no_write", txn), 32'(imem_we), 32'd0);
      check_eq($sformatf("t%0d_err_code", txn), 32'(err_code), 32'(e_code));
      exp_code = e_code;
      last_code = 32'(err_code);
    end else begin
      check_eq($sformatf("t%0d_we", txn), 32'(imem_we), 32'd1);
      check_eq($sformatf("t%0d_no_err", txn), 32'(err_valid), 32'd0);
      check_eq($sformatf("t%0d_wdata", txn), imem_wdata, e_word);
      check_eq($sformatf("t%0d_addr", txn), 32'(imem_addr), 32'(exp_addr));
      check_eq($sformatf("t%0d_code_clr", txn), 32'(err_code), 32'd0);
      last_word = imem_wdata;
      last_addr = 32'(imem_addr);
      exp_addr = (exp_addr + 1) % (1 << AW);
      exp_code = 0;
    end
    $display("txn %0d cls=%0d imm32=0x%08h lat=%0d we=%0b err=%0b word=0x%08h code=%0d",
             txn, cls, v, lat, imem_we, err_valid, imem_wdata, err_code);
    @(posedge clk); #1;
    check_eq($sformatf("t%0d_strobe_end", txn), 32'(imem_we | err_valid), 32'd0);
    check_eq($sformatf("t%0d_ready_back", txn), 32'(req_ready), 32'd1);
    check_eq($sformatf("t%0d_addr_after", txn), 32'(imem_addr), 32'(exp_addr));
    check_eq($sformatf("t%0d_code_hold", txn), 32'(err_code), 32'(exp_code));
  endtask

  function automatic logic [31:0] rand_imm();
    int          mode;
    longint      b, r;
    logic [31:0] v;
    mode = int'($urandom_range(0, 3));
    case (mode)
      0: begin
        b = longint'($urandom_range(0, 255));
        r = longint'($urandom_range(0, 15));
        v = 32'((b << (32 - 2 * r)) | (b >> (2 * r)));
      end
      1: v = 32'(longint'($urandom_range(0, 10000)) - 5000);
      2: v = $urandom;
      default: begin
        b = longint'($urandom_range(0, 5));
        v = ($urandom_range(0, 1) == 1) ? 32'((64'sd1 <<< 25) - 8 + 4 * b) : 32'(-(64'sd1 <<< 25) - 8 + 4 * b);
      end
    endcase
    return v;
  endfunction

  int pulses;
  int r10;
  logic [1:0] rc;

  initial begin
    rst_n = 1'b0; start = 1'b0; req_valid = 1'b0;
    req_class = '0; req_cond = '0; req_cmd = '0; req_s = 1'b0; req_imm = 1'b0;
    req_rn = '0; req_rd = '0; req_rm = '0; req_imm32 = '0;
    last_word = '0; last_addr = '0; last_code = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_err_valid", 32'(err_valid), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test-plan vectors
    do_req(2'd0, 4'hE, 4'hD, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 32'h0000_00FF);
    check_eq("tp_dp_rot0", last_word, 32'hE3A0_10FF);
    check_eq("tp_dp_rot0_addr", last_addr, 32'd0);
    do_req(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h3F00_0000);
`ifdef ENC_ROT_SEARCH_EN
    check_eq("tp_dp_rot4", last_word, 32'hE281_243F);
`else
    check_eq("tp_dp_rot4_err", last_code, 32'd1);
`endif
    do_req(2'd0, 4'hE, 4'h4, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h0000_0101);
    do_req(2'd1, 4'hE, 4'h0, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 32'hFFFF_FFF8);
    check_eq("tp_load_neg", last_word, 32'hE513_4008);
    do_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFF8);
    check_eq("tp_branch", last_word, 32'hEAFF_FFFE);
    do_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd6);
    check_eq("tp_branch_mis", last_code, 32'd3);

    // Boundaries
    do_req(2'd1, 4'h1, 4'h0, 1'b0, 1'b0, 4'd5, 4'd6, 4'd0, 32'd4095);
    do_req(2'd1, 4'h1, 4'h0, 1'b0, 1'b0, 4'd5, 4'd6, 4'd0, 32'd4096);
    do_req(2'd1, 4'h2, 4'h0, 1'b1, 1'b0, 4'd5, 4'd6, 4'd0, 32'hFFFF_F001);
    do_req(2'd1, 4'h2, 4'h0, 1'b1, 1'b0, 4'd5, 4'd6, 4'd0, 32'h8000_0000);
    do_req(2'd2, 4'h3, 4'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h01FF_FFFC);
    do_req(2'd2, 4'h3, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0200_0000);
    do_req(2'd2, 4'h3, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'hFE00_0000);
    do_req(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
    do_req(2'd0, 4'h0, 4'hF, 1'b1, 1'b0, 4'd7, 4'd8, 4'd9, 32'hDEAD_BEEF);
    do_req(2'd0, 4'hE, 4'h2, 1'b1, 1'b1, 4'd1, 4'd1, 4'd0, 32'h0000_0004);

    // Randomized requests
    for (int i = 0; i < 70; i++) begin
      r10 = int'($urandom_range(0, 9));
      rc = (r10 < 5) ? 2'd0 : (r10 < 7) ? 2'd1 : (r10 < 9) ? 2'd2 : 2'd3;
      do_req(rc, 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
             4'($urandom), 4'($urandom), 4'($urandom), rand_imm());
    end

    // Reset in the middle of an operation
    do_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
    do_req(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
    req_class = 2'd0; req_imm = 1'b1; req_imm32 = 32'h0000_0101; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_we", 32'(imem_we), 32'd0);
    check_eq("mid_rst_addr", 32'(imem_addr), 32'd0);
    check_eq("mid_rst_err_valid", 32'(err_valid), 32'd0);
    check_eq("mid_rst_err_code", 32'(err_code), 32'd0);
    check_eq("mid_rst_wdata", imem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr = 0; exp_code = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (imem_we || err_valid) pulses++;
    end
    check_eq("mid_rst_no_activity", 32'(pulses), 32'd0);
    $display("reset-abort done pulses=%0d addr=%0d", pulses, imem_addr);

    // start together with a request: start wins, address reloads
    do_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd8);
    do_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd12);
    start = 1'b1; req_valid = 1'b1; req_class = 2'd2; req_imm32 = 32'd0;
    #1;
    check_eq("start_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; req_valid = 1'b0;
    exp_addr = 0;
    check_eq("start_addr_reload", 32'(imem_addr), 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (imem_we || err_valid) pulses++;
    end
    check_eq("start_no_accept", 32'(pulses), 32'd0);
    check_eq("start_ready_back", 32'(req_ready), 32'd1);
    $display("start-vs-request done addr=%0d", imem_addr);

    // Address wrap: the 17th write from BASE lands at address 0 again
    for (int k = 0; k < 17; k++) begin
      do_req(2'd2, 4'hE, 4'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 32'(4 * k));
      if (k == 0) check_eq("wrap_first_addr", last_addr, 32'd0);
    end
    check_eq("wrap_17th_addr", last_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder for the single-cycle ARM-subset core, mirroring the instruction decoder. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit instruction words. Data-processing immediates are searched for an 8-bit rotated form. Each encoded word is written into the instruction-memory load port at an auto-incrementing word address, which lets the testbench or boot loader build programs in hardware.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, word address loaded at reset and on `start`
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  reload address counter with BASE_ADDR (honoured only in IDLE)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when `req_valid && req_ready`
- req_class  in  2  Op: 00 DP, 01 load/store, 10 branch, 11 unsupported
- req_cond  in  4  condition field, bits 31:28
- req_cmd  in  4  DP command, bits 24:21
- req_s  in  1  S bit (DP), L bit (mem), link bit (branch)
- req_imm  in  1  DP operand2 is an immediate
- req_rn, req_rd, req_rm  in  4 each  register fields
- req_imm32  in  32  raw DP immediate, signed mem offset, or signed byte branch offset
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address of the next write
- imem_wdata  out  32  encoded instruction
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  0 none, 1 DP immediate unencodable, 2 mem offset out of range, 3 branch misaligned or out of range, 4 unsupported class

## Operation
- Register all request fields on acceptance.
- FSM states: IDLE, ROT, WRITE, ERR.
- IDLE:
  - `req_ready = !start`. A simultaneous `start` and `req_valid` resolves in favour of `start`.
  - Accept → ROT if class 00 with `req_imm`.
  - Accept → ERR if validation fails.
  - Otherwise accept → WRITE.
- DP word: `{cond, 2'b00, req_imm, cmd, S, Rn, Rd, op2}`.
  - Register form: op2 = `{8'b0, Rm}`.
  - Immediate form: op2 = `{rot, imm8}`, where `req_imm32 == ROR(imm8, 2*rot)`.
- ROT: test rot = 0,1,…,15, one candidate per cycle.
  - On the first match → WRITE, which gives the lowest rot.
  - After rot 15 fails → ERR with code 1.
- Load/store word: `{cond, 01, I=0, P=1, U, B=0, W=0, L=req_s, Rn, Rd, imm12}`.
  - U = 1 when `req_imm32 >= 0`; imm12 = |req_imm32|.
  - |req_imm32| > 4095 → code 2.
- Branch word: `{cond, 10, 1, L, req_imm32[25:2]}`.
  - `req_imm32[1:0] != 0`, or `req_imm32` outside [-2^25, 2^25-4] → code 3.
- Class 11 → code 4.
- WRITE: `imem_we = 1`, `imem_wdata` valid, `imem_addr` holds the target address. `imem_addr` increments on the next edge, wrapping modulo 2^ADDR_W. Then → IDLE.
- ERR: `err_valid = 1`, no write, address unchanged. Then → IDLE.
- `err_code` holds its value until the next error or until a successful write clears it to 0.

## Timing
- Reset values: state IDLE, `req_ready = 1`, `imem_we = 0`, `imem_wdata = 0`, `imem_addr = BASE_ADDR`, `err_valid = 0`, `err_code = 0`.
- Cycle numbering: the request is accepted at edge N.
- Non-ROT requests: `imem_we` or `err_valid` is high in cycle N+1, and `req_ready` returns in cycle N+2.
- DP immediate matching at rot r: `imem_we` is high in cycle N+2+r.
- Unencodable DP immediate: `err_valid` is high in cycle N+17.
- Maximum back-to-back throughput is one instruction per 2 cycles.
- `req_ready` is low in ROT, WRITE and ERR.
- Reset asserted mid-operation aborts immediately. No write occurs and all outputs return to their reset values.

## Configuration
- `ENC_ROT_SEARCH_EN` defined: full 16-step rotation search, as described above.
- `ENC_ROT_SEARCH_EN` undefined:
  - ROT state omitted.
  - DP immediates are encodable only when `req_imm32[31:8] == 0`, using rot 0.
  - Encodable immediates go straight to WRITE (imem_we in cycle N+1).
  - All other immediates go to ERR with code 1 in cycle N+1.

## Structure
- `enc_pkg` holds:
  - the op-class enum (DP, MEM, BR, UNSUP);
  - the error-code localparams;
  - the FSM state enum;
  - the field bit-position constants shared with the decoder.
- Sub-module `enc_rot_check`: combinational; inputs imm32 and rot, outputs match and imm8. Instantiated once and driven by the ROT counter.

## Test plan
- DP immediate with rot 0: cond E, cmd 1101, Rd 1, imm32 0xFF → `imem_wdata` 0xE3A010FF at BASE_ADDR in cycle N+1; address then BASE_ADDR+1.
- DP immediate needing rotation: cmd 0100, Rn 1, Rd 2, imm32 0x3F000000 → 0xE281243F in cycle N+6 (rot 4). Without the macro: err_code 1 in cycle N+1.
- Unencodable immediate: imm32 0x00000101 → `err_valid` in cycle N+17, err_code 1, no `imem_we`, address unchanged.
- Load with negative offset: class 01, L=1, Rn 3, Rd 4, imm32 −8 → 0xE5134008.
- Branch: imm32 −8 → 0xEAFFFFFE. Branch with imm32 6 → err_code 3.
- Wrap and reset:
  - ADDR_W=4 with BASE_ADDR 0: the 17th write lands at address 0.
  - `rst_n` low during ROT: no write, `req_ready` = 1.
  - `start` together with `req_valid` in IDLE: request not accepted, address reloaded.
